sample_mixer: RTL
=================

SAMPLE_MIXER -- requirements
Module: sample_mixer

Interface
REQ-001 Parameter NVOICES, default 3, number of voice inputs mixed (2..4).
REQ-002 Parameter TIMEOUT, default 1023, cycles allowed between first and last voice capture of a frame.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 voice_sample  input  16*NVOICES  per-voice enveloped sample, two's complement; voice i in bits [16i+15:16i].
REQ-006 voice_valid  input  NVOICES  one-cycle pulse per voice; voice_sample slice is valid in that cycle.
REQ-007 voice_enable  input  NVOICES  level; voice participates in mixing when high.
REQ-008 volume_shift  input  3  master attenuation, arithmetic right shift 0..7 applied to the sum.
REQ-009 codec_ready  input  1  level; downstream codec accepts sample_out when high together with sample_valid.
REQ-010 sample_out  output  16  mixed, saturated two's complement sample.
REQ-011 sample_valid  output  1  sample_out valid; held until accepted.
REQ-012 clip  output  1  high with sample_valid when the current sample was saturated.
REQ-013 dropped  output  1  sticky; set when any voice_valid pulse is discarded.

Function
REQ-014 FSM states COLLECT, SUM, OUTPUT; reset state COLLECT.
REQ-015 COLLECT: voice_valid[i] with voice_enable[i] high and voice i not yet captured latches the slice into capture register i and sets captured[i].
REQ-016 COLLECT -> SUM in the cycle after captured covers every enabled voice, with at least one voice enabled and captured.
REQ-017 A timeout counter SHALL start at the first capture of a frame; on reaching TIMEOUT, COLLECT -> SUM with uncaptured voices contributing zero.
REQ-018 With no voice enabled, the FSM SHALL remain in COLLECT and produce no sample.
REQ-019 SUM (one cycle): 18-bit signed sum of captured registers of enabled voices; uncaptured or disabled voices contribute zero.
REQ-020 The sum SHALL be shifted right arithmetically by volume_shift, then saturated to [-32768, 32767]; clip set if saturation changed the value.
REQ-021 SUM -> OUTPUT unconditionally; latency from the capturing edge of the last voice to sample_valid high is 2 cycles.
REQ-022 OUTPUT: sample_valid high, sample_out and clip stable until a cycle with codec_ready high; that edge clears sample_valid, clip, all captured bits and the timeout counter, and returns the FSM to COLLECT.
REQ-023 voice_valid for an already-captured voice, or arriving in SUM or OUTPUT, SHALL be discarded and set dropped.
REQ-024 voice_valid with voice_enable low SHALL be ignored without setting dropped.
REQ-025 Deasserting voice_enable[i] in COLLECT SHALL clear captured[i]; reasserting requires a new capture.
REQ-026 volume_shift is sampled in SUM only; changes in OUTPUT do not alter the held sample.

Reset
REQ-027 Reset SHALL asynchronously force COLLECT, clear capture registers, captured bits and timeout counter, and drive sample_out=0, sample_valid=0, clip=0, dropped=0.
REQ-028 Reset mid-frame or while sample_valid is high SHALL discard the frame; no sample emitted after reset deassertion until a new frame completes.

Structure
REQ-029 State encodings (2-bit COLLECT=0, SUM=1, OUTPUT=2) and sample width SHALL live in the shared audio defines file used by the dynamics and player blocks.
REQ-030 Saturation SHALL be a separate sub-module sat16 (18-bit signed in, 16-bit out plus clip flag); state and capture registers use the existing dffr/dffre flip-flop cells.

Verification
REQ-031 Voices 0..2 enabled, pulse samples 1000, 2000, -500 on cycles 1,3,5, codec_ready=1, shift 0 -> sample_valid at cycle 7, sample_out=2500, clip=0.
REQ-032 Three voices each 30000, shift 0 -> sample_out=32767, clip=1; each -30000 -> -32768, clip=1; same with shift 2 -> 22500, clip=0.
REQ-033 Voices 0,1 enabled, only voice 0 pulses 4000, TIMEOUT=16 -> sample_valid 16 cycles after capture plus 2, sample_out=4000.
REQ-034 codec_ready low 10 cycles while sample_valid high, voice 0 pulses again -> sample_out stable, dropped=1; codec_ready high -> one acceptance, FSM back to COLLECT.
REQ-035 Assert reset while in OUTPUT -> sample_valid, sample_out, dropped immediately 0; no sample emitted until a full new frame is collected.

Source files
------------

// File: rtl/sample_mixer_pkg.sv
// Shared audio definitions: sample widths and mixer FSM state encoding.
package sample_mixer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SUM_W    = 18;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SUM     = 2'd1,
    ST_OUTPUT  = 2'd2
  } mix_state_e;

endpackage

// File: rtl/sample_mixer_sat16.sv
// Saturates an 18-bit signed value into the 16-bit sample range and flags clipping.
module sat16
  import sample_mixer_pkg::*;
(
  input  logic signed [SUM_W-1:0]    din,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       clip
);

  localparam logic signed [SUM_W-1:0] MAX_V = 18'sd32767;
  localparam logic signed [SUM_W-1:0] MIN_V = -18'sd32768;

  // Returns {clip, value}.
  function automatic logic [SAMPLE_W:0] sat(input logic signed [SUM_W-1:0] x);
    if (x > MAX_V)      return {1'b1, 16'h7FFF};
    else if (x < MIN_V) return {1'b1, 16'h8000};
    else                return {1'b0, x[SAMPLE_W-1:0]};
  endfunction

  // Pure combinational clamp.
  always_comb begin
    {clip, dout} = sat(din);
  end

endmodule

// File: rtl/sample_mixer.sv
// Voice mixer: collects one sample per enabled voice, sums, attenuates,
// saturates and holds the result until the codec accepts it.
module sample_mixer
  import sample_mixer_pkg::*;
#(
  parameter int NVOICES = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SAMPLE_W*NVOICES-1:0] voice_sample,
  input  logic [NVOICES-1:0]          voice_valid,
  input  logic [NVOICES-1:0]          voice_enable,
  input  logic [2:0]                  volume_shift,
  input  logic                        codec_ready,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic                        sample_valid,
  output logic                        clip,
  output logic                        dropped
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  mix_state_e state_q, state_d;

  logic [NVOICES-1:0][SAMPLE_W-1:0] cap_q;
  logic [NVOICES-1:0]               captured_q, captured_d, cap_en;
  logic [TMR_W-1:0]                 tmr_q;
  logic                             tmr_run_q;

  logic in_collect, in_sum, in_output;
  logic all_in, timed_out, go_sum, accept, drop_any;

  logic signed [SUM_W-1:0]    sum_p0, shifted_p0, ext_p0;
  logic signed [SAMPLE_W-1:0] sat_out_p0;
  logic                       sat_clip_p0;

  // Frame completion: every enabled voice in, or the timeout expired with something captured.
  assign all_in    = (|voice_enable) && ((captured_q & voice_enable) == voice_enable);
  assign timed_out = tmr_run_q && (tmr_q == TMR_W'(TIMEOUT)) && (|(captured_q & voice_enable));
  assign go_sum    = all_in || timed_out;
  assign accept    = in_output && codec_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_COLLECT;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (go_sum) state_d = ST_SUM;
      ST_SUM:     state_d = ST_OUTPUT;
      ST_OUTPUT:  if (codec_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // State decode.
  always_comb begin
    in_collect = (state_q == ST_COLLECT);
    in_sum     = (state_q == ST_SUM);
    in_output  = (state_q == ST_OUTPUT);
  end

  assign sample_valid = in_output;

  // Per-voice capture/drop decisions; a disabled voice loses its pending capture.
  always_comb begin
    cap_en     = '0;
    drop_any   = 1'b0;
    captured_d = captured_q;
    for (int i = 0; i < NVOICES; i++) begin
      if (in_collect && !voice_enable[i]) begin
        captured_d[i] = 1'b0;
      end else if (voice_valid[i] && voice_enable[i]) begin
        if (in_collect && !go_sum && !captured_q[i]) begin
          cap_en[i]     = 1'b1;
          captured_d[i] = 1'b1;
        end else begin
          drop_any = 1'b1;
        end
      end
    end
    if (accept) captured_d = '0;
  end

  // Capture registers and captured flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q      <= '0;
      captured_q <= '0;
    end else begin
      captured_q <= captured_d;
      for (int i = 0; i < NVOICES; i++) begin
        if (cap_en[i]) cap_q[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Frame timeout counter: starts on the first capture, saturates at TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q     <= '0;
      tmr_run_q <= 1'b0;
    end else if (accept) begin
      tmr_q     <= '0;
      tmr_run_q <= 1'b0;
    end else if (!tmr_run_q && (|cap_en)) begin
      tmr_q     <= '0;
      tmr_run_q <= 1'b1;
    end else if (tmr_run_q && (tmr_q != TMR_W'(TIMEOUT))) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // Stage p0: sum of captured enabled voices, then arithmetic attenuation.
  always_comb begin
    sum_p0 = '0;
    ext_p0 = '0;
    for (int i = 0; i < NVOICES; i++) begin
      ext_p0 = {{(SUM_W-SAMPLE_W){cap_q[i][SAMPLE_W-1]}}, cap_q[i]};
      if (captured_q[i] && voice_enable[i]) sum_p0 = sum_p0 + ext_p0;
    end
    shifted_p0 = sum_p0 >>> volume_shift;
  end

  sat16 u_sat16 (
    .din  (shifted_p0),
    .dout (sat_out_p0),
    .clip (sat_clip_p0)
  );

  // Output hold registers: loaded in SUM, clip cleared on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_out <= '0;
      clip       <= 1'b0;
    end else if (in_sum) begin
      sample_out <= sat_out_p0;
      clip       <= sat_clip_p0;
    end else if (accept) begin
      clip <= 1'b0;
    end
  end

  // Sticky discarded-pulse flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         dropped <= 1'b0;
    else if (drop_any) dropped <= 1'b1;
  end

endmodule
